// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - prioritised interrupt controller with bus registers; optional IRQ_CTRL_EDGE_DETECT_EN
module irq_controller #(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src,
    output logic               IRQ,
    input  logic               IACK,
    input  logic               sel,
    input  logic [3:0]         addr,
    input  logic [31:0]        wdata,
    input  logic [3:0]         we,
    output logic [31:0]        rdata,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_enable;
    logic               r_cause_valid;
    logic [ID_W-1:0]    r_cause_id;
    logic               r_irq;
    logic               r_busy;

    logic [NUM_SRC-1:0] w_pending_next;
    logic [NUM_SRC-1:0] w_active;
    logic [NUM_SRC-1:0] w_src_mask;
    logic [NUM_SRC-1:0] w_wr_bits;
    logic [NUM_SRC-1:0] w_win_onehot;
    logic [ID_W-1:0]    w_win_id;
    logic               w_any;
    logic               w_wr;
    logic               w_wr_pending;
    logic               w_wr_enable;
    logic               w_wr_eoi;
    logic               w_capture;
    logic               w_eoi_accept;
    logic               w_unused;

    assign w_wr         = sel && (we != 4'b0000);
    assign w_wr_pending = w_wr && (addr[3:2] == 2'd0);
    assign w_wr_enable  = w_wr && (addr[3:2] == 2'd1);
    assign w_wr_eoi     = w_wr && (addr[3:2] == 2'd3);
    assign w_active     = r_pending & r_enable;
    assign w_any        = |w_active;
    assign w_wr_bits    = wdata[NUM_SRC-1:0] & w_src_mask;
    assign w_unused     = ^{addr[1:0], wdata[31:NUM_SRC]};

    assign IRQ  = r_irq;
    assign busy = r_busy;

    // Expand byte enables to a per-source bit mask
    always_comb begin
        w_src_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_src_mask[i] = we[i / 8];
        end
    end

    // Fixed priority: the lowest active index wins
    always_comb begin
        w_win_id     = '1;
        w_win_onehot = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_win_id     = ID_W'(i);
                w_win_onehot = '0;
                w_win_onehot[i] = 1'b1;
            end
        end
    end

`ifdef IRQ_CTRL_EDGE_DETECT_EN
    logic [NUM_SRC-1:0] r_src_prev;
    logic [NUM_SRC-1:0] w_clr;

    // Rising edges set pending; clears from software or capture lose to a same-cycle set
    always_comb begin
        w_clr = '0;
        if (w_wr_pending)
            w_clr = w_clr | w_wr_bits;
        if (w_capture && w_any)
            w_clr = w_clr | w_win_onehot;
        w_pending_next = (r_pending & ~w_clr) | (src & ~r_src_prev);
    end

    // Source history for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_src_prev <= '0;
        else
            r_src_prev <= src;
    end
`else
    logic w_unused_level;
    assign w_unused_level = ^{w_wr_pending, w_win_onehot};

    // Level mode: pending simply mirrors the sampled source lines
    always_comb begin
        w_pending_next = src;
    end
`endif

    // Request/service sequencing
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_eoi_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any)
                    w_state_next = S_REQ;
            end
            S_REQ: begin
                if (IACK) begin
                    w_state_next = S_SERVICE;
                    w_capture    = 1'b1;
                end
            end
            S_SERVICE: begin
                if (w_wr_eoi) begin
                    w_state_next = S_IDLE;
                    w_eoi_accept = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register with IRQ and busy registered from the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_irq   <= (w_state_next == S_REQ);
            r_busy  <= (w_state_next == S_SERVICE);
        end
    end

    // Pending, enable and cause registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending     <= '0;
            r_enable      <= '0;
            r_cause_valid <= 1'b0;
            r_cause_id    <= '0;
        end else begin
            r_pending <= w_pending_next;
            if (w_wr_enable)
                r_enable <= (r_enable & ~w_src_mask) | w_wr_bits;
            if (w_capture) begin
                // Active vector gone by acknowledge time means a spurious interrupt
                r_cause_valid <= w_any;
                r_cause_id    <= w_any ? w_win_id : '1;
            end else if (w_eoi_accept) begin
                r_cause_valid <= 1'b0;
                r_cause_id    <= '0;
            end
        end
    end

    // Combinational register read-back
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr[3:2])
                2'd0: rdata[NUM_SRC-1:0] = r_pending;
                2'd1: rdata[NUM_SRC-1:0] = r_enable;
                2'd2: begin
                    rdata[31]        = r_cause_valid;
                    rdata[ID_W-1:0]  = r_cause_id;
                end
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - self-checking bench for irq_controller
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  src;
    logic        IRQ;
    logic        IACK;
    logic        sel;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;
    bit running = 1'b0;

    irq_controller #(.NUM_SRC(8), .ID_W(5)) dut (
        .clk(clk), .reset(reset), .src(src), .IRQ(IRQ), .IACK(IACK),
        .sel(sel), .addr(addr), .wdata(wdata), .we(we), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0]  m_pending, m_enable, m_prev, m_act, m_np, m_bm;
    logic [31:0] m_cause;
    bit          m_req, m_busy, m_wr;
    int          m_first;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pending = 0; m_enable = 0; m_prev = 0; m_cause = 0;
            m_req = 0; m_busy = 0;
        end else begin
            m_wr = sel && (we != 0);
            m_bm = {8{we[0]}};
            m_act = m_pending & m_enable;
            m_first = -1;
            for (int i = 7; i >= 0; i--) if (m_act[i]) m_first = i;
`ifdef IRQ_CTRL_EDGE_DETECT_EN
            m_np = m_pending;
            if (m_wr && addr[3:2] == 2'd0) m_np = m_np & ~(wdata[7:0] & m_bm);
            if (m_req && IACK && m_first >= 0) m_np[m_first] = 1'b0;
            m_np = m_np | (src & ~m_prev);
            m_prev = src;
`else
            m_np = src;
`endif
            if (m_wr && addr[3:2] == 2'd1) m_enable = (m_enable & ~m_bm) | (wdata[7:0] & m_bm);
            if (m_busy) begin
                if (m_wr && addr[3:2] == 2'd3) begin m_busy = 0; m_cause = 0; end
            end else if (m_req) begin
                if (IACK) begin
                    m_req = 0; m_busy = 1;
                    m_cause = (m_first >= 0) ? (32'h8000_0000 | m_first) : 32'h0000_001F;
                end
            end else if (m_act != 0) begin
                m_req = 1;
            end
            m_pending = m_np;
        end
    end

    function automatic logic [31:0] m_rdata();
        if (!sel) return 32'h0;
        case (addr[3:2])
            2'd0: return {24'h0, m_pending};
            2'd1: return {24'h0, m_enable};
            2'd2: return m_cause;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            if (running) begin
                chk("model_irq", {31'h0, IRQ}, {31'h0, m_req});
                chk("model_busy", {31'h0, busy}, {31'h0, m_busy});
                chk("model_rdata", rdata, m_rdata());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] w);
        sel = 1'b1; addr = a; wdata = d; we = w;
        tick();
        sel = 1'b0; we = 4'h0; wdata = 32'h0;
    endtask

    task automatic rd(input string name, input logic [3:0] a, input logic [31:0] exp);
        tick();
        sel = 1'b1; addr = a; we = 4'h0;
        #1 chk(name, rdata, exp);
        sel = 1'b0;
    endtask

    task automatic pulse_iack();
        IACK = 1'b1;
        tick();
        IACK = 1'b0;
    endtask

    initial begin
        reset = 1'b0; src = 8'hFF; IACK = 1'b0; sel = 1'b0;
        addr = 4'h0; wdata = 32'h0; we = 4'h0;
        running = 1'b1;
        repeat (3) tick();
        chk("rst_irq", {31'h0, IRQ}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        rd("rst_pending", 4'h0, 32'h0);
        rd("rst_enable", 4'h4, 32'h0);
        rd("rst_cause", 4'h8, 32'h0);
        rd("rst_eoi", 4'hC, 32'h0);

        reset = 1'b1;
        tick();
        chk("rel_irq", {31'h0, IRQ}, 32'h0);
        rd("rel_pending", 4'h0, 32'h0000_00FF);

        src = 8'h0C;
        wr(4'h0, 32'h0000_00F3, 4'hF);
        rd("pend_0c", 4'h0, 32'h0000_000C);

        wr(4'h4, 32'hFFFF_FFFF, 4'b1110);
        rd("enable_byte_mask", 4'h4, 32'h0);

        wr(4'h4, 32'h0000_000C, 4'hF);
        chk("en_irq_not_yet", {31'h0, IRQ}, 32'h0);
        tick();
        chk("en_irq_high", {31'h0, IRQ}, 32'h1);
        rd("en_readback", 4'h4, 32'h0000_000C);
        chk("irq_held", {31'h0, IRQ}, 32'h1);

        pulse_iack();
        chk("ack_irq_low", {31'h0, IRQ}, 32'h0);
        chk("ack_busy", {31'h0, busy}, 32'h1);
        rd("ack_cause", 4'h8, 32'h8000_0002);
`ifdef IRQ_CTRL_EDGE_DETECT_EN
        rd("ack_pending", 4'h0, 32'h0000_0008);
`else
        rd("ack_pending", 4'h0, 32'h0000_000C);
`endif

        src = 8'h0D;
        tick();
        src = 8'h0C;
        tick();
        tick();
        chk("svc_no_irq", {31'h0, IRQ}, 32'h0);
        src = 8'h08;
        tick();
        tick();
        wr(4'hC, 32'h0, 4'b0001);
        chk("eoi_busy", {31'h0, busy}, 32'h0);
        chk("eoi_irq_not_yet", {31'h0, IRQ}, 32'h0);
        tick();
        chk("reraise_irq", {31'h0, IRQ}, 32'h1);
        rd("reraise_cause_clear", 4'h8, 32'h0);
        pulse_iack();
        rd("reraise_cause", 4'h8, 32'h8000_0003);
        src = 8'h00;
        wr(4'hC, 32'h0, 4'hF);
        tick();
        tick();
        chk("quiet_irq", {31'h0, IRQ}, 32'h0);

        src = 8'h08;
        tick();
        tick();
        chk("spur_irq", {31'h0, IRQ}, 32'h1);
        wr(4'h4, 32'h0, 4'hF);
        chk("spur_irq_held", {31'h0, IRQ}, 32'h1);
        pulse_iack();
        chk("spur_irq_low", {31'h0, IRQ}, 32'h0);
        chk("spur_busy", {31'h0, busy}, 32'h1);
        rd("spur_cause", 4'h8, 32'h0000_001F);
        wr(4'hC, 32'h0, 4'hF);
        chk("spur_eoi_busy", {31'h0, busy}, 32'h0);
        rd("spur_cause_clear", 4'h8, 32'h0);

        src = 8'h28;
        wr(4'h0, 32'h0000_0020, 4'hF);
        sel = 1'b1; addr = 4'h0;
        #1 chk("set_beats_clear", {31'h0, rdata[5]}, 32'h1);
        sel = 1'b0;

        wr(4'h4, 32'h0000_0028, 4'hF);
        tick();
        chk("pre_rst_irq", {31'h0, IRQ}, 32'h1);
        pulse_iack();
        chk("pre_rst_busy", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        sel = 1'b1; addr = 4'h8;
        #1;
        chk("arst_irq", {31'h0, IRQ}, 32'h0);
        chk("arst_busy", {31'h0, busy}, 32'h0);
        chk("arst_cause", rdata, 32'h0);
        addr = 4'h0;
        #1 chk("arst_pending", rdata, 32'h0);
        addr = 4'h4;
        #1 chk("arst_enable", rdata, 32'h0);
        sel = 1'b0;

        tick();
        tick();
        reset = 1'b1;
        tick();
        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
